uart_cfg_regs: RTL and testbench
================================

Name: uart_cfg_regs

Overview:
- Register/configuration front end of the uDMA UART, directly downstream of the cfg agent's bus.
- Decodes single-word cfg bus reads and writes and holds the line setup (divisor, data bits, parity, stop bits, enables).
- Stages each setup change in a shadow register. The change is applied to the TX/RX cores only when both are idle, so no frame is ever corrupted mid-flight.
- Collects sticky RX error flags and drives the error interrupt.

Parameters:
- ADDR_W, 5: cfg byte-address width; bits [4:2] select the word.
- DATA_W, 32: cfg data width.
- DEFAULT_DIV, 16'h0010: reset value of the clock divisor.

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  reset; asynchronous, active-low
- cfg_valid_i  in  1  access request
- cfg_rwn_i  in  1  1 = read, 0 = write
- cfg_addr_i  in  ADDR_W  byte address
- cfg_data_i  in  DATA_W  write data
- cfg_ready_o  out  1  access accepted
- cfg_data_o  out  DATA_W  read data, registered
- tx_busy_i  in  1  TX core mid-frame
- rx_busy_i  in  1  RX core mid-frame
- err_overflow_i  in  1  RX overflow pulse
- err_parity_i  in  1  RX parity-error pulse
- cfg_div_o  out  16  active clock divisor
- cfg_bits_o  out  2  active data bits: 00=5, 01=6, 10=7, 11=8
- cfg_parity_en_o  out  1  active parity enable
- cfg_stop_bits_o  out  1  active stop bits: 0 = 1 stop bit, 1 = 2 stop bits
- cfg_tx_en_o  out  1  active TX enable
- cfg_rx_en_o  out  1  active RX enable
- cfg_update_o  out  1  one-cycle pulse when the active setup changes
- err_irq_o  out  1  error interrupt

Behaviour:

Register map (word offsets):
- 0x00 STATUS (RO):
  - [0] tx_busy_i
  - [1] rx_busy_i
  - [2] update pending
- 0x04 SETUP (RW):
  - [0] parity_en
  - [2:1] bits
  - [3] stop
  - [8] tx_en
  - [9] rx_en
  - [31:16] clkdiv
  - Reads return the shadow value.
- 0x08 ERROR (RO, clear-on-read):
  - [0] overflow
  - [1] parity
- 0x0C IRQ_EN (RW):
  - [1] err_irq_en
  - Other bits read 0.
- Unmapped addresses: reads return 0, writes are ignored.

Cfg bus:
- cfg_ready_o is tied to 1; every valid access is accepted in its request cycle.
- Read data appears on cfg_data_o in the cycle after acceptance and holds until the next read.
- Reserved bits read 0.

Reset:
- All outputs are 0 except cfg_div_o = DEFAULT_DIV and cfg_bits_o = 2'b11.
- Shadow equals active; pending = 0; error flags = 0; IRQ_EN = 0.
- Reset asserted mid-update discards the pending shadow.

Apply FSM (states IDLE, PENDING):
- IDLE to PENDING: a SETUP write in cycle N loads the shadow and sets pending at edge N.
  - A clkdiv write of 0 is stored as 1.
- PENDING to IDLE: on the first clock edge where pending=1, tx_busy_i=0 and rx_busy_i=0:
  - active <= shadow and pending <= 0;
  - cfg_update_o = 1 for exactly the following cycle.
  - Minimum latency from write to active is 1 cycle.
- While PENDING with a busy core, the active outputs are frozen.
- A second SETUP write while PENDING overwrites the shadow (last write wins) and stays PENDING.
- A SETUP write in the same cycle as the apply edge:
  - the old shadow is applied;
  - the new value loads the shadow;
  - pending stays 1, and the new value applies at the next idle edge.

Errors:
- err_overflow_i and err_parity_i set their sticky bit.
- An accepted read of ERROR clears both bits at the same edge; the read data carries the pre-clear value.
- A set and a clear in the same cycle: the set wins, and the bit stays 1.
- err_irq_o = err_irq_en & (overflow | parity), registered (one cycle after the flag).

Decomposition:
- Package uart_cfg_pkg holds:
  - word offset constants (STATUS, SETUP, ERROR, IRQ_EN);
  - SETUP bitfield position constants;
  - a packed struct uart_setup_t {clkdiv, rx_en, tx_en, stop, bits, parity_en};
  - the apply-FSM state enum.
- One sub-module, uart_err_sticky: sticky flags with set-priority clear-on-read, plus the IRQ register.

Test Plan:
- Reset then read all four registers -> STATUS=0, SETUP=0x0010_0006, ERROR=0, IRQ_EN=0; cfg_div_o=0x0010 and cfg_bits_o=11 before any access.
- Write SETUP=0x01B2_0307 with both busy inputs low -> cfg_update_o pulses 1 cycle later; cfg_div_o=0x01B2, bits=11, parity=1, tx_en=rx_en=1.
- Hold tx_busy_i=1, then:
  - write SETUP=0x0040_0100 -> STATUS[2]=1 and active outputs unchanged;
  - write SETUP=0x0080_0100 -> shadow overwritten;
  - drop tx_busy_i -> only 0x0080 is applied, with a single cfg_update_o pulse.
- Write SETUP with clkdiv=0 -> SETUP read returns clkdiv=1, and cfg_div_o=1 after apply.
- IRQ_EN[1]=1, pulse err_parity_i -> err_irq_o=1. Read ERROR -> returns 0x2 and clears to 0; err_irq_o falls.
- Pulse err_overflow_i in the same cycle as an accepted ERROR read -> that read returns the old value, the flag remains 1, and the next read returns 0x1.

Source files
------------

// File: rtl/uart_cfg_pkg.sv
// Shared definitions for the uDMA UART cfg register front end: word map,
// SETUP field layout, setup struct and apply-FSM states.
package uart_cfg_pkg;

    localparam logic [2:0] WORD_STATUS = 3'd0;
    localparam logic [2:0] WORD_SETUP  = 3'd1;
    localparam logic [2:0] WORD_ERROR  = 3'd2;
    localparam logic [2:0] WORD_IRQ_EN = 3'd3;

    localparam int SETUP_PARITY_BIT = 0;
    localparam int SETUP_BITS_LSB   = 1;
    localparam int SETUP_STOP_BIT   = 3;
    localparam int SETUP_TXEN_BIT   = 8;
    localparam int SETUP_RXEN_BIT   = 9;
    localparam int SETUP_DIV_LSB    = 16;
    localparam int IRQ_EN_ERR_BIT   = 1;

    typedef struct packed {
        logic [15:0] clkdiv;
        logic        rx_en;
        logic        tx_en;
        logic        stop;
        logic [1:0]  bits;
        logic        parity_en;
    } uart_setup_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } apply_state_e;

    // A zero divisor would stall the baud generator, so it is promoted to 1.
    function automatic uart_setup_t setup_from_word(input logic [31:0] w);
        uart_setup_t s;
        s.clkdiv    = (w[SETUP_DIV_LSB +: 16] == 16'd0) ? 16'd1 : w[SETUP_DIV_LSB +: 16];
        s.rx_en     = w[SETUP_RXEN_BIT];
        s.tx_en     = w[SETUP_TXEN_BIT];
        s.stop      = w[SETUP_STOP_BIT];
        s.bits      = w[SETUP_BITS_LSB +: 2];
        s.parity_en = w[SETUP_PARITY_BIT];
        return s;
    endfunction

    function automatic logic [31:0] setup_to_word(input uart_setup_t s);
        logic [31:0] w;
        w                       = '0;
        w[SETUP_DIV_LSB +: 16]  = s.clkdiv;
        w[SETUP_RXEN_BIT]       = s.rx_en;
        w[SETUP_TXEN_BIT]       = s.tx_en;
        w[SETUP_STOP_BIT]       = s.stop;
        w[SETUP_BITS_LSB +: 2]  = s.bits;
        w[SETUP_PARITY_BIT]     = s.parity_en;
        return w;
    endfunction

endpackage

// File: rtl/uart_cfg_regs_err.sv
// Sticky RX error flags (set beats clear-on-read) and the registered error IRQ.
module uart_err_sticky (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_set_ovf,
    input  logic       i_set_par,
    input  logic       i_clr,
    input  logic       i_irq_en,
    output logic [1:0] o_flags,
    output logic       o_irq
);

    logic [1:0] r_flags;
    logic       r_irq;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_flags <= 2'b00;
            r_irq   <= 1'b0;
        end else begin
            r_flags <= (i_clr ? 2'b00 : r_flags) | {i_set_par, i_set_ovf};
            r_irq   <= i_irq_en & (|r_flags);
        end
    end

    assign o_flags = r_flags;
    assign o_irq   = r_irq;

endmodule

// File: rtl/uart_cfg_regs.sv
// UART cfg register front end: bus decode, shadowed line setup applied only
// when both TX and RX cores are idle, and sticky error reporting.
module uart_cfg_regs
    import uart_cfg_pkg::*;
#(
    parameter int          ADDR_W      = 5,
    parameter int          DATA_W      = 32,
    parameter logic [15:0] DEFAULT_DIV = 16'h0010
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              cfg_valid_i,
    input  logic              cfg_rwn_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [DATA_W-1:0] cfg_data_i,
    output logic              cfg_ready_o,
    output logic [DATA_W-1:0] cfg_data_o,
    input  logic              tx_busy_i,
    input  logic              rx_busy_i,
    input  logic              err_overflow_i,
    input  logic              err_parity_i,
    output logic [15:0]       cfg_div_o,
    output logic [1:0]        cfg_bits_o,
    output logic              cfg_parity_en_o,
    output logic              cfg_stop_bits_o,
    output logic              cfg_tx_en_o,
    output logic              cfg_rx_en_o,
    output logic              cfg_update_o,
    output logic              err_irq_o
);

    localparam uart_setup_t SETUP_RST = '{clkdiv: DEFAULT_DIV, rx_en: 1'b0, tx_en: 1'b0,
                                          stop: 1'b0, bits: 2'b11, parity_en: 1'b0};

    logic [2:0]        w_word;
    logic              w_rd;
    logic              w_wr;
    logic              w_setup_wr;
    logic              w_irqen_wr;
    logic              w_err_rd;
    logic              w_apply;
    logic [1:0]        w_err_flags;
    logic [DATA_W-1:0] w_rdata;
    logic [1:0]        w_unused;
    apply_state_e      r_state;
    apply_state_e      w_state_next;
    uart_setup_t       r_shadow;
    uart_setup_t       r_active;
    logic              r_update;
    logic              r_irq_en;
    logic [DATA_W-1:0] r_rdata;

    assign w_word     = cfg_addr_i[4:2];
    assign w_unused   = cfg_addr_i[1:0];
    assign w_rd       = cfg_valid_i &  cfg_rwn_i;
    assign w_wr       = cfg_valid_i & ~cfg_rwn_i;
    assign w_setup_wr = w_wr && (w_word == WORD_SETUP);
    assign w_irqen_wr = w_wr && (w_word == WORD_IRQ_EN);
    assign w_err_rd   = w_rd && (w_word == WORD_ERROR);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    // A write landing on the apply edge keeps us PENDING for the new value.
    always_comb begin
        w_state_next = r_state;
        w_apply      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_setup_wr) w_state_next = ST_PENDING;
            end
            ST_PENDING: begin
                w_apply = !tx_busy_i && !rx_busy_i;
                if (w_apply && !w_setup_wr) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_shadow <= SETUP_RST;
            r_active <= SETUP_RST;
            r_update <= 1'b0;
            r_irq_en <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_setup_wr) r_shadow <= setup_from_word(cfg_data_i[31:0]);
            if (w_apply)    r_active <= r_shadow;
            r_update <= w_apply;
            if (w_irqen_wr) r_irq_en <= cfg_data_i[IRQ_EN_ERR_BIT];
            if (w_rd)       r_rdata  <= w_rdata;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_word)
            WORD_STATUS: w_rdata[2:0] = {r_state == ST_PENDING, rx_busy_i, tx_busy_i};
            WORD_SETUP:  w_rdata = DATA_W'(setup_to_word(r_shadow));
            WORD_ERROR:  w_rdata[1:0] = w_err_flags;
            WORD_IRQ_EN: w_rdata[IRQ_EN_ERR_BIT] = r_irq_en;
            default:     w_rdata = '0;
        endcase
    end

    uart_err_sticky u_err (
        .i_clk     (clk_i),
        .i_rst_n   (rstn_i),
        .i_set_ovf (err_overflow_i),
        .i_set_par (err_parity_i),
        .i_clr     (w_err_rd),
        .i_irq_en  (r_irq_en),
        .o_flags   (w_err_flags),
        .o_irq     (err_irq_o)
    );

    assign cfg_ready_o     = 1'b1;
    assign cfg_data_o      = r_rdata;
    assign cfg_div_o       = r_active.clkdiv;
    assign cfg_bits_o      = r_active.bits;
    assign cfg_parity_en_o = r_active.parity_en;
    assign cfg_stop_bits_o = r_active.stop;
    assign cfg_tx_en_o     = r_active.tx_en;
    assign cfg_rx_en_o     = r_active.rx_en;
    assign cfg_update_o    = r_update;

endmodule

// File: tb/tb_uart_cfg_regs.sv
// Bench for uart_cfg_regs: word-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_cfg_regs;

    logic        clk = 1'b0;
    logic        rstn_i = 1'b0;
    logic        cfg_valid_i = 1'b0;
    logic        cfg_rwn_i = 1'b0;
    logic [4:0]  cfg_addr_i = '0;
    logic [31:0] cfg_data_i = '0;
    logic        tx_busy_i = 1'b0;
    logic        rx_busy_i = 1'b0;
    logic        err_overflow_i = 1'b0;
    logic        err_parity_i = 1'b0;
    logic        cfg_ready_o;
    logic [31:0] cfg_data_o;
    logic [15:0] cfg_div_o;
    logic [1:0]  cfg_bits_o;
    logic        cfg_parity_en_o, cfg_stop_bits_o, cfg_tx_en_o, cfg_rx_en_o;
    logic        cfg_update_o, err_irq_o;

    always #5 clk = ~clk;

    uart_cfg_regs dut (
        .clk_i           (clk),
        .rstn_i          (rstn_i),
        .cfg_valid_i     (cfg_valid_i),
        .cfg_rwn_i       (cfg_rwn_i),
        .cfg_addr_i      (cfg_addr_i),
        .cfg_data_i      (cfg_data_i),
        .cfg_ready_o     (cfg_ready_o),
        .cfg_data_o      (cfg_data_o),
        .tx_busy_i       (tx_busy_i),
        .rx_busy_i       (rx_busy_i),
        .err_overflow_i  (err_overflow_i),
        .err_parity_i    (err_parity_i),
        .cfg_div_o       (cfg_div_o),
        .cfg_bits_o      (cfg_bits_o),
        .cfg_parity_en_o (cfg_parity_en_o),
        .cfg_stop_bits_o (cfg_stop_bits_o),
        .cfg_tx_en_o     (cfg_tx_en_o),
        .cfg_rx_en_o     (cfg_rx_en_o),
        .cfg_update_o    (cfg_update_o),
        .err_irq_o       (err_irq_o)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: registers kept as plain 32-bit words in the map layout.
    logic [31:0] m_shadow, m_active, m_rdata;
    logic        m_pend, m_upd, m_irq, m_irqen, m_apply;
    logic [1:0]  m_flags;
    logic [2:0]  m_word;

    function automatic logic [31:0] sani(input logic [31:0] d);
        logic [31:0] m;
        m = d & 32'hFFFF_030F;
        if (m[31:16] == 16'd0) m[31:16] = 16'd1;
        return m;
    endfunction

    always @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            m_shadow = 32'h0010_0006;
            m_active = 32'h0010_0006;
            m_rdata  = '0;
            m_pend   = 1'b0;
            m_upd    = 1'b0;
            m_irq    = 1'b0;
            m_irqen  = 1'b0;
            m_flags  = 2'b00;
        end else begin
            m_word  = cfg_addr_i[4:2];
            m_apply = m_pend && !tx_busy_i && !rx_busy_i;
            if (cfg_valid_i && cfg_rwn_i) begin
                case (m_word)
                    3'd0:    m_rdata = {29'd0, m_pend, rx_busy_i, tx_busy_i};
                    3'd1:    m_rdata = m_shadow;
                    3'd2:    m_rdata = {30'd0, m_flags};
                    3'd3:    m_rdata = {30'd0, m_irqen, 1'b0};
                    default: m_rdata = 32'd0;
                endcase
            end
            m_irq   = m_irqen && (m_flags != 2'b00);
            m_flags = ((cfg_valid_i && cfg_rwn_i && m_word == 3'd2) ? 2'b00 : m_flags)
                      | {err_parity_i, err_overflow_i};
            m_upd   = m_apply;
            if (m_apply) m_active = m_shadow;
            if (cfg_valid_i && !cfg_rwn_i && m_word == 3'd1) begin
                m_shadow = sani(cfg_data_i);
                m_pend   = 1'b1;
            end else if (m_apply) begin
                m_pend = 1'b0;
            end
            if (cfg_valid_i && !cfg_rwn_i && m_word == 3'd3) m_irqen = cfg_data_i[1];
        end
    end

    always @(negedge clk) begin
        chk("ready",  {31'd0, cfg_ready_o}, 32'd1);
        chk("rdata",  cfg_data_o, m_rdata);
        chk("div",    {16'd0, cfg_div_o}, {16'd0, m_active[31:16]});
        chk("bits",   {30'd0, cfg_bits_o}, {30'd0, m_active[2:1]});
        chk("parity", {31'd0, cfg_parity_en_o}, {31'd0, m_active[0]});
        chk("stop",   {31'd0, cfg_stop_bits_o}, {31'd0, m_active[3]});
        chk("tx_en",  {31'd0, cfg_tx_en_o}, {31'd0, m_active[8]});
        chk("rx_en",  {31'd0, cfg_rx_en_o}, {31'd0, m_active[9]});
        chk("update", {31'd0, cfg_update_o}, {31'd0, m_upd});
        chk("irq",    {31'd0, err_irq_o}, {31'd0, m_irq});
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_valid_i = 1'b1; cfg_rwn_i = 1'b0; cfg_addr_i = a; cfg_data_i = d;
        @(negedge clk);
        cfg_valid_i = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic ovf, output logic [31:0] d);
        @(negedge clk);
        cfg_valid_i = 1'b1; cfg_rwn_i = 1'b1; cfg_addr_i = a; err_overflow_i = ovf;
        @(negedge clk);
        cfg_valid_i = 1'b0; err_overflow_i = 1'b0;
        d = cfg_data_o;
    endtask

    task automatic pulse_parity();
        @(negedge clk);
        err_parity_i = 1'b1;
        @(negedge clk);
        err_parity_i = 1'b0;
    endtask

    logic [31:0] rdv;
    int          nupd;

    initial begin
        repeat (3) @(negedge clk);
        chk("lit_rst_div", {16'd0, cfg_div_o}, 32'h0000_0010);
        chk("lit_rst_bits", {30'd0, cfg_bits_o}, 32'd3);
        rstn_i = 1'b1;
        rd(5'h00, 1'b0, rdv); chk("lit_status0", rdv, 32'h0);
        rd(5'h04, 1'b0, rdv); chk("lit_setup0", rdv, 32'h0010_0006);
        rd(5'h08, 1'b0, rdv); chk("lit_error0", rdv, 32'h0);
        rd(5'h0C, 1'b0, rdv); chk("lit_irqen0", rdv, 32'h0);

        wr(5'h04, 32'h01B2_0307);
        @(negedge clk);
        chk("lit_upd1", {31'd0, cfg_update_o}, 32'd1);
        chk("lit_div1", {16'd0, cfg_div_o}, 32'h01B2);
        chk("lit_cfg1", {26'd0, cfg_rx_en_o, cfg_tx_en_o, cfg_stop_bits_o, cfg_bits_o, cfg_parity_en_o},
            32'b11_0_11_1);

        tx_busy_i = 1'b1;
        wr(5'h04, 32'h0040_0100);
        rd(5'h00, 1'b0, rdv); chk("lit_status_pend", rdv, 32'h5);
        chk("lit_div_frozen", {16'd0, cfg_div_o}, 32'h01B2);
        wr(5'h04, 32'h0080_0100);
        rd(5'h04, 1'b0, rdv); chk("lit_shadow_ovr", rdv, 32'h0080_0100);
        @(negedge clk);
        tx_busy_i = 1'b0;
        nupd = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cfg_update_o) nupd++;
        end
        chk("lit_one_pulse", nupd, 32'd1);
        chk("lit_div80", {16'd0, cfg_div_o}, 32'h0080);

        wr(5'h04, 32'h0000_0106);
        rd(5'h04, 1'b0, rdv); chk("lit_div0_read", rdv, 32'h0001_0106);
        chk("lit_div0_act", {16'd0, cfg_div_o}, 32'h1);

        wr(5'h0C, 32'h0000_0002);
        pulse_parity();
        @(negedge clk);
        chk("lit_irq_set", {31'd0, err_irq_o}, 32'd1);
        rd(5'h08, 1'b0, rdv); chk("lit_err_par", rdv, 32'h2);
        @(negedge clk);
        chk("lit_irq_fall", {31'd0, err_irq_o}, 32'd0);
        rd(5'h08, 1'b0, rdv); chk("lit_err_clr", rdv, 32'h0);

        pulse_parity();
        rd(5'h08, 1'b1, rdv); chk("lit_err_race_old", rdv, 32'h2);
        rd(5'h08, 1'b0, rdv); chk("lit_err_race_new", rdv, 32'h1);
        rd(5'h08, 1'b0, rdv); chk("lit_err_race_clr", rdv, 32'h0);

        tx_busy_i = 1'b1;
        wr(5'h04, 32'h1234_0300);
        #2 rstn_i = 1'b0;
        @(negedge clk);
        chk("lit_rst_mid_div", {16'd0, cfg_div_o}, 32'h0010);
        rstn_i = 1'b1;
        tx_busy_i = 1'b0;
        rd(5'h04, 1'b0, rdv); chk("lit_rst_mid_shadow", rdv, 32'h0010_0006);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cfg_valid_i    = ($urandom_range(0, 2) != 0);
            cfg_rwn_i      = $urandom_range(0, 1);
            cfg_addr_i     = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 3) << 2)
                                                         : 5'($urandom);
            cfg_data_i     = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_FFFF) : $urandom;
            err_overflow_i = ($urandom_range(0, 7) == 0);
            err_parity_i   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 5) == 0) tx_busy_i = ~tx_busy_i;
            if ($urandom_range(0, 5) == 0) rx_busy_i = ~rx_busy_i;
            if (i == 1500) begin
                #2 rstn_i = 1'b0;
                @(negedge clk);
                rstn_i = 1'b1;
            end
        end
        @(negedge clk);
        cfg_valid_i = 1'b0; err_overflow_i = 1'b0; err_parity_i = 1'b0;
        tx_busy_i = 1'b0; rx_busy_i = 1'b0;
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
